// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - memory handshake bundle between control unit and memory port
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM with memory waits, MDU slot and trap
module multicycle_ctrl #(
    parameter int MEXT_EN       = 1,
    parameter int MDU_LATENCY   = 32,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [6:0]               opcode,
    input  logic                     funct7_b0,
    input  logic                     branch_cond,
    multicycle_ctrl_if.master        mem,
    output logic                     pc_write,
    output logic                     ir_write,
    output logic [1:0]               result_src,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic [2:0]               imm_src,
    output logic                     reg_write,
    output logic                     mdu_start,
    output logic                     instr_done,
    output logic                     illegal_instr,
    output logic [3:0]               state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALRADR  = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_MDU      = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [5:0] MDU_LOAD = 6'(MDU_LATENCY - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       mdu_flag_q, mdu_flag_d;
    // run_q holds the FSM in FETCH until the first edge after reset release
    logic       run_q;
    logic       mem_ok;

    // With the handshake disabled every memory state completes in one cycle
    assign mem_ok  = (MEM_HANDSHAKE == 0) || mem.mem_ready;
    assign state_o = state_q;

    // Next-state and Moore output decode; everything is zeroed until run_q is set
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mdu_flag_d    = mdu_flag_q;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        mdu_start     = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        mem.adr_src   = 1'b0;

        case (opcode)
            OP_LOAD, OP_JALR, OP_ITYPE: imm_src = 3'b000;
            OP_STORE:                   imm_src = 3'b001;
            OP_BRANCH:                  imm_src = 3'b010;
            OP_JAL:                     imm_src = 3'b011;
            OP_LUI, OP_AUIPC:           imm_src = 3'b100;
            default:                    imm_src = 3'b000;
        endcase

        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                if (mem_ok) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if ((MEXT_EN != 0) && funct7_b0) begin
                            state_d = S_MDU;
                            cnt_d   = MDU_LOAD;
                        end else begin
                            state_d = S_EXECR;
                        end
                    end
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALRADR;
                    OP_LUI:    state_d = S_LUI;
                    OP_AUIPC:  state_d = S_AUIPC;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem.mem_req = 1'b1;
                mem.adr_src = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem.mem_req   = 1'b1;
                mem.mem_write = 1'b1;
                mem.adr_src   = 1'b1;
                if (mem_ok) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = mdu_flag_q ? 2'b11 : 2'b00;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                mdu_flag_d = 1'b0;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write   = branch_cond;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALRADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_MDU: begin
                // counter only equals the load value on the entry cycle
                mdu_start = (cnt_q == MDU_LOAD);
                if (cnt_q == 6'd0) begin
                    state_d    = S_ALUWB;
                    mdu_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                imm_src       = 3'b000;
            end
            default: state_d = S_FETCH;
        endcase

        if (!run_q) begin
            state_d       = S_FETCH;
            cnt_d         = cnt_q;
            mdu_flag_d    = mdu_flag_q;
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            result_src    = 2'b00;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            imm_src       = 3'b000;
            reg_write     = 1'b0;
            mdu_start     = 1'b0;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
            mem.mem_req   = 1'b0;
            mem.mem_write = 1'b0;
            mem.adr_src   = 1'b0;
        end
    end

    // State, MDU counter and MDU-writeback flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            state_q    <= S_FETCH;
            cnt_q      <= 6'd0;
            mdu_flag_q <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mdu_flag_q <= mdu_flag_d;
        end
    end

endmodule
